// File: rtl/push_button_debouncer.sv
// ----------------------------------------------------------------------------
// push_button_debouncer
//
// Purpose:
//   Turns the four active-low board push buttons into clean debounced levels
//   plus single-cycle press / release pulses. A free-running divider produces
//   the sample tick. Each raw button goes through a two-flop synchronizer and
//   then a per-button shift register that is loaded once per tick. The level
//   only changes once the whole register agrees.
//
// Optional feature:
//   PB_AUTO_REPEAT_EN - when defined, each button gets a repeat FSM and a
//   16-bit hold counter. Holding a button then produces extra press pulses:
//   the first comes REPEAT_DELAY ticks after the initial press, and the rest
//   follow every REPEAT_PERIOD ticks. When undefined, PRESS_PULSE_O fires
//   once per debounced press and no repeat logic is built.
//
// Parameters:
//   TICK_DIV        clock cycles per sample tick (>= 2)
//   DEBOUNCE_DEPTH  consecutive agreeing samples to change level (2..16)
//   REPEAT_DELAY    ticks held before the first repeat pulse (>= 1)
//   REPEAT_PERIOD   ticks between later repeat pulses (>= 1)
//
// Ports:
//   CLOCK_50_I       system clock
//   RESET_I          synchronous active-high reset
//   PUSH_BUTTON_N_I  raw buttons, 0 = pressed
//   BUTTON_LEVEL_O   debounced level, 1 = pressed
//   PRESS_PULSE_O    one-cycle pulse per debounced press (and per repeat)
//   RELEASE_PULSE_O  one-cycle pulse per debounced release
//   TICK_O           one-cycle sample tick, also exported downstream
// ----------------------------------------------------------------------------

// Per-button debounce lane: shift register, level, pulses, optional repeat.
//   clk, rst       shared clock and synchronous reset
//   tick           sample strobe from the divider
//   sample         synchronized button sample, 1 = pressed
//   level          debounced level
//   press_pulse    debounced press, OR'd with repeat pulses when enabled
//   release_pulse  debounced release
module pb_lane #(
    parameter int DEBOUNCE_DEPTH = 10,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sample,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    logic [DEBOUNCE_DEPTH-1:0] shift_q;
    logic                      all_ones;
    logic                      all_zeros;
    logic                      repeat_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else if (tick) begin
            shift_q <= {shift_q[DEBOUNCE_DEPTH-2:0], sample};
        end
    end

    assign all_ones  = &shift_q;
    assign all_zeros = ~|shift_q;

    // Pulses are computed from the same condition that moves the level, so
    // each pulse shows up in the first cycle the new level is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            if (all_ones) begin
                level <= 1'b1;
            end else if (all_zeros) begin
                level <= 1'b0;
            end
            press_pulse   <= (all_ones & ~level) | repeat_fire;
            release_pulse <= all_zeros & level;
        end
    end

`ifdef PB_AUTO_REPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    localparam logic [15:0] DELAY_CNT  = 16'(REPEAT_DELAY);
    localparam logic [15:0] PERIOD_CNT = 16'(REPEAT_PERIOD);

    rep_state_t  state;
    rep_state_t  state_next;
    logic [15:0] hold_cnt;
    logic [15:0] hold_cnt_next;
    logic [15:0] cmp_val;

    assign cmp_val = (state == ST_REPEAT) ? PERIOD_CNT : DELAY_CNT;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // Next-state logic. The counter reaches the compare value in the cycle
    // after a tick, is cleared right there, and a new tick cannot land in
    // that same cycle (TICK_DIV >= 2), so it never exceeds the compare value.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        unique case (state)
            ST_IDLE: begin
                hold_cnt_next = '0;
                if (level) begin
                    state_next = ST_HOLD;
                    // With very short dividers a tick can coincide with the
                    // first cycle the level reads 1; it belongs to the hold.
                    if (tick) begin
                        hold_cnt_next = 16'd1;
                    end
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!level) begin
                    // Release has priority over a repeat due this cycle.
                    state_next    = ST_IDLE;
                    hold_cnt_next = '0;
                end else if (hold_cnt == cmp_val) begin
                    state_next    = ST_REPEAT;
                    hold_cnt_next = '0;
                end else if (tick) begin
                    hold_cnt_next = hold_cnt + 16'd1;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        repeat_fire = 1'b0;
        if ((state != ST_IDLE) && level && (hold_cnt == cmp_val)) begin
            repeat_fire = 1'b1;
        end
    end
`else
    // Repeat timing parameters are accepted but have no effect in this build.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign repeat_fire       = 1'b0;
`endif

endmodule

module push_button_debouncer #(
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_DEPTH = 10,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100
) (
    input  logic       CLOCK_50_I,
    input  logic       RESET_I,
    input  logic [3:0] PUSH_BUTTON_N_I,
    output logic [3:0] BUTTON_LEVEL_O,
    output logic [3:0] PRESS_PULSE_O,
    output logic [3:0] RELEASE_PULSE_O,
    output logic       TICK_O
);

    localparam int                NUM_LANES = 4;
    localparam int                DIV_W     = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0]     div_cnt;
    logic [NUM_LANES-1:0] sync_meta;
    logic [NUM_LANES-1:0] sync_q;

    // Sample-tick divider; the tick is registered, so it lands one cycle
    // after the counter shows its last value.
    always_ff @(posedge CLOCK_50_I) begin
        if (RESET_I) begin
            div_cnt <= '0;
            TICK_O  <= 1'b0;
        end else begin
            TICK_O  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Two-flop synchronizer on the inverted (active-high) buttons.
    always_ff @(posedge CLOCK_50_I) begin
        if (RESET_I) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= ~PUSH_BUTTON_N_I;
            sync_q    <= sync_meta;
        end
    end

    pb_lane #(
        .DEBOUNCE_DEPTH(DEBOUNCE_DEPTH),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_lane [NUM_LANES-1:0] (
        .clk          (CLOCK_50_I),
        .rst          (RESET_I),
        .tick         (TICK_O),
        .sample       (sync_q),
        .level        (BUTTON_LEVEL_O),
        .press_pulse  (PRESS_PULSE_O),
        .release_pulse(RELEASE_PULSE_O)
    );

endmodule

// File: tb/tb_push_button_debouncer.sv
// ----------------------------------------------------------------------------
// tb_push_button_debouncer
//
// Self-checking bench for push_button_debouncer with TICK_DIV=4,
// DEBOUNCE_DEPTH=3, REPEAT_DELAY=5, REPEAT_PERIOD=2. A reference model keeps
// the raw input history and the list of tick samples per button. From these
// it derives the tick, level, press and release outputs for every cycle.
// Repeat pulses are expected at fixed cycle offsets from the press, and only
// when PB_AUTO_REPEAT_EN is defined.
// ----------------------------------------------------------------------------
module tb_push_button_debouncer;

    localparam int TD = 4;
    localparam int DD = 3;
    localparam int RD = 5;
    localparam int RP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pb_n = 4'hF;
    logic [3:0] lvl, press, rel;
    logic       tick;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    push_button_debouncer #(
        .TICK_DIV(TD), .DEBOUNCE_DEPTH(DD), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .CLOCK_50_I     (clk),
        .RESET_I        (rst),
        .PUSH_BUTTON_N_I(pb_n),
        .BUTTON_LEVEL_O (lvl),
        .PRESS_PULSE_O  (press),
        .RELEASE_PULSE_O(rel),
        .TICK_O         (tick)
    );

    // ---------------- reference model ----------------
    int         n;            // cycles since the last reset edge
    logic [3:0] raw_q[$];     // raw_q[m] = pressed buttons during cycle m
    bit         samp[4][$];   // tick samples per button, oldest first
    int         pcyc[4];      // cycle of the latest debounced press
    logic [3:0] exp_lvl, exp_press, exp_rel;
    logic       exp_tick;

    function automatic void model_clear();
        n = 0;
        raw_q.delete();
        for (int b = 0; b < 4; b++) begin
            samp[b].delete();
            for (int k = 0; k < DD; k++) samp[b].push_back(1'b0);
            pcyc[b] = 0;
        end
        exp_lvl = '0; exp_press = '0; exp_rel = '0; exp_tick = 1'b0;
    endfunction

    // Advance one clock and update the model. Outputs are sampled #1 after
    // the edge; inputs are changed by callers only after this returns.
    task automatic step();
        logic       rst_at_edge;
        logic [3:0] nl;
        bit         ones, zeros, s;
        rst_at_edge = rst;
        raw_q.push_back(~pb_n);
        @(posedge clk);
        #1;
        if (rst_at_edge) begin
            model_clear();
        end else begin
            n++;
            exp_tick = (n >= TD) && (n % TD == 0);
            // A tick in cycle t sees the raw value of cycle t-2; the
            // level moves two cycles after that tick.
            if ((n - 2 >= TD) && ((n - 2) % TD == 0))
                for (int b = 0; b < 4; b++) samp[b].push_back(raw_q[n-4][b]);
            nl = exp_lvl;
            for (int b = 0; b < 4; b++) begin
                ones = 1'b1; zeros = 1'b1;
                for (int k = 1; k <= DD; k++) begin
                    s = samp[b][samp[b].size()-k];
                    ones  = ones & s;
                    zeros = zeros & !s;
                end
                if (ones) nl[b] = 1'b1;
                else if (zeros) nl[b] = 1'b0;
            end
            exp_press = nl & ~exp_lvl;
            exp_rel   = ~nl & exp_lvl;
`ifdef PB_AUTO_REPEAT_EN
            for (int b = 0; b < 4; b++) begin
                if (exp_press[b]) pcyc[b] = n;
                else if (nl[b] && exp_lvl[b] && (n - pcyc[b] >= TD*RD) &&
                         ((n - pcyc[b] - TD*RD) % (TD*RP) == 0))
                    exp_press[b] = 1'b1;
            end
`endif
            exp_lvl = nl;
        end
    endtask

    task automatic do_reset(input int k);
        rst = 1'b1;
        for (int i = 0; i < k; i++) step();
        rst = 1'b0;
    endtask

    function automatic int first_tick_after(input int m);
        int t;
        t = m + 2;
        if (t < TD) t = TD;
        if (t % TD != 0) t += TD - (t % TD);
        return t;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int rise, tcnt;
        pb_n = 4'hE;
        rst  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if ({tick, lvl, press, rel} !== 13'h0) begin
                fails++;
                $display("FAIL reset_outputs got %b/%h/%h/%h required all 0", tick, lvl, press, rel);
            end
        end
        rst = 1'b0; rise = -1; tcnt = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            tests++;
            if ({tick, lvl, press, rel} !== {exp_tick, exp_lvl, exp_press, exp_rel}) begin
                fails++;
                $display("FAIL reset_run n=%0d got %b/%h/%h/%h exp %b/%h/%h/%h",
                         n, tick, lvl, press, rel, exp_tick, exp_lvl, exp_press, exp_rel);
            end
            if (tick) tcnt++;
            if (lvl[0] && rise < 0) rise = n;
        end
        tests++;
        if (rise !== 14) begin
            fails++; $display("FAIL reset_level_rise got cycle %0d required 14", rise);
        end
        tests++;
        if (tcnt !== 10) begin
            fails++; $display("FAIL reset_tick_count got %0d required 10", tcnt);
        end
        pb_n = 4'hF;
    endtask

    task automatic test_clean_press();
        int m, rise, pcnt, exp_rise;
        bit other;
        pb_n = 4'hF;
        do_reset(2);
        for (int c = 0; c < int'($urandom_range(0, 7)); c++) step();
        m = n; pb_n[0] = 1'b0;
        exp_rise = first_tick_after(m) + 2*TD + 2;
        rise = -1; pcnt = 0; other = 1'b0;
        for (int c = 0; c < 20*TD; c++) begin
            step();
            tests++;
            if ({tick, lvl, press, rel} !== {exp_tick, exp_lvl, exp_press, exp_rel}) begin
                fails++;
                $display("FAIL clean_press n=%0d got %b/%h/%h/%h exp %b/%h/%h/%h",
                         n, tick, lvl, press, rel, exp_tick, exp_lvl, exp_press, exp_rel);
            end
            if (lvl[0] && rise < 0) rise = n;
            if (press[0]) pcnt++;
            if (|{lvl[3:1], press[3:1], rel[3:1]}) other = 1'b1;
        end
        tests++;
        if (rise !== exp_rise) begin
            fails++; $display("FAIL press_latency got cycle %0d required %0d", rise, exp_rise);
        end
        tests++;
        if (other !== 1'b0) begin
            fails++; $display("FAIL press_other_bits got activity required none");
        end
`ifndef PB_AUTO_REPEAT_EN
        tests++;
        if (pcnt !== 1) begin
            fails++; $display("FAIL press_count got %0d required 1", pcnt);
        end
`endif
        pb_n = 4'hF;
    endtask

    task automatic test_bounce();
        bit moved;
        pb_n = 4'hF;
        do_reset(2);
        for (int c = 0; c < int'($urandom_range(0, 7)); c++) step();
        moved = 1'b0;
        for (int c = 0; c < 10*TD + 30; c++) begin
            if (c < 10*TD && (c % TD == 0)) pb_n[1] = ~pb_n[1];
            if (c == 10*TD) pb_n[1] = 1'b1;
            step();
            tests++;
            if ({tick, lvl, press, rel} !== {exp_tick, exp_lvl, exp_press, exp_rel}) begin
                fails++;
                $display("FAIL bounce n=%0d got %b/%h/%h/%h exp %b/%h/%h/%h",
                         n, tick, lvl, press, rel, exp_tick, exp_lvl, exp_press, exp_rel);
            end
            if (lvl[1] | press[1] | rel[1]) moved = 1'b1;
        end
        tests++;
        if (moved !== 1'b0) begin
            fails++; $display("FAIL bounce_activity got movement on button 1 required none");
        end
    endtask

    task automatic test_release();
        int m, rcnt, rcyc, exp_cyc;
        pb_n = 4'hF;
        do_reset(2);
        pb_n[2] = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            tests++;
            if ({tick, lvl, press, rel} !== {exp_tick, exp_lvl, exp_press, exp_rel}) begin
                fails++;
                $display("FAIL release_fill n=%0d got %b/%h/%h/%h exp %b/%h/%h/%h",
                         n, tick, lvl, press, rel, exp_tick, exp_lvl, exp_press, exp_rel);
            end
        end
        for (int c = 0; c < int'($urandom_range(0, 7)); c++) step();
        m = n; pb_n[2] = 1'b1;
        exp_cyc = first_tick_after(m) + 2*TD + 2;
        rcnt = 0; rcyc = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            tests++;
            if ({tick, lvl, press, rel} !== {exp_tick, exp_lvl, exp_press, exp_rel}) begin
                fails++;
                $display("FAIL release n=%0d got %b/%h/%h/%h exp %b/%h/%h/%h",
                         n, tick, lvl, press, rel, exp_tick, exp_lvl, exp_press, exp_rel);
            end
            if (rel[2]) begin rcnt++; rcyc = n; end
        end
        tests++;
        if (rcnt !== 1 || rcyc !== exp_cyc) begin
            fails++;
            $display("FAIL release_pulse got count %0d at %0d required 1 at %0d", rcnt, rcyc, exp_cyc);
        end
        tests++;
        if (lvl[2] !== 1'b0) begin
            fails++; $display("FAIL release_level got %b required 0", lvl[2]);
        end
    endtask

    task automatic test_auto_repeat();
        int p, offs[$], exp_offs[$];
        bit found;
        pb_n = 4'hF;
        do_reset(2);
        pb_n[3] = 1'b0;
        found = 1'b0; p = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (press[3]) begin found = 1'b1; p = n; end
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL repeat_first_press got none within 40 cycles required a pulse");
        end
        offs.push_back(0);
        for (int c = 1; c < 12*TD; c++) begin
            step();
            tests++;
            if ({tick, lvl, press, rel} !== {exp_tick, exp_lvl, exp_press, exp_rel}) begin
                fails++;
                $display("FAIL repeat n=%0d got %b/%h/%h/%h exp %b/%h/%h/%h",
                         n, tick, lvl, press, rel, exp_tick, exp_lvl, exp_press, exp_rel);
            end
            if (press[3]) offs.push_back((n - p) / TD);
        end
        exp_offs.push_back(0);
`ifdef PB_AUTO_REPEAT_EN
        exp_offs.push_back(5); exp_offs.push_back(7);
        exp_offs.push_back(9); exp_offs.push_back(11);
`endif
        tests++;
        if (offs.size() !== exp_offs.size()) begin
            fails++;
            $display("FAIL repeat_count got %0d pulses required %0d", offs.size(), exp_offs.size());
        end else begin
            for (int i = 0; i < offs.size(); i++) begin
                tests++;
                if (offs[i] !== exp_offs[i]) begin
                    fails++;
                    $display("FAIL repeat_offset[%0d] got %0d ticks required %0d", i, offs[i], exp_offs[i]);
                end
            end
        end
        pb_n = 4'hF;
        for (int c = 0; c < 20; c++) step();
    endtask

    task automatic test_simultaneous();
        bit seen_p, seen_r;
        int rise;
        pb_n = 4'hF;
        do_reset(2);
        for (int c = 0; c < int'($urandom_range(0, 7)); c++) step();
        pb_n = 4'h0;
        seen_p = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (!seen_p && press != 4'h0) begin
                seen_p = 1'b1;
                tests++;
                if (press !== 4'hF) begin
                    fails++; $display("FAIL sim_press got %h required f", press);
                end
            end
        end
        pb_n = 4'hF;
        seen_r = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (!seen_r && rel != 4'h0) begin
                seen_r = 1'b1;
                tests++;
                if (rel !== 4'hF) begin
                    fails++; $display("FAIL sim_release got %h required f", rel);
                end
            end
        end
        tests++;
        if ({seen_p, seen_r} !== 2'b11) begin
            fails++; $display("FAIL sim_seen got %b required 11", {seen_p, seen_r});
        end
        // Reset while all four are held: nothing may pulse, and the held
        // buttons must refill the register from scratch afterwards.
        pb_n = 4'h0;
        for (int c = 0; c < 30; c++) step();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            tests++;
            if ({tick, lvl, press, rel} !== 13'h0) begin
                fails++;
                $display("FAIL sim_reset got %b/%h/%h/%h required all 0", tick, lvl, press, rel);
            end
        end
        rst = 1'b0; rise = -1;
        for (int c = 0; c < 30; c++) begin
            step();
            tests++;
            if ({tick, lvl, press, rel} !== {exp_tick, exp_lvl, exp_press, exp_rel}) begin
                fails++;
                $display("FAIL sim_after_reset n=%0d got %b/%h/%h/%h exp %b/%h/%h/%h",
                         n, tick, lvl, press, rel, exp_tick, exp_lvl, exp_press, exp_rel);
            end
            if (lvl == 4'hF && rise < 0) rise = n;
        end
        tests++;
        if (rise !== 14) begin
            fails++; $display("FAIL sim_refill got cycle %0d required 14", rise);
        end
        pb_n = 4'hF;
    endtask

    task automatic test_random();
        int hold[4];
        pb_n = 4'hF;
        do_reset(2);
        for (int b = 0; b < 4; b++) hold[b] = 1;
        for (int c = 0; c < 900; c++) begin
            for (int b = 0; b < 4; b++) begin
                hold[b]--;
                if (hold[b] <= 0) begin
                    pb_n[b] = ~pb_n[b];
                    hold[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6))
                                                          : int'($urandom_range(10, 80));
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
            tests++;
            if ({tick, lvl, press, rel} !== {exp_tick, exp_lvl, exp_press, exp_rel}) begin
                fails++;
                $display("FAIL random n=%0d got %b/%h/%h/%h exp %b/%h/%h/%h",
                         n, tick, lvl, press, rel, exp_tick, exp_lvl, exp_press, exp_rel);
            end
        end
        rst = 1'b0;
        pb_n = 4'hF;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_auto_repeat();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
